// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared MIPS constants, memory FSM encoding, default I/O address
// Revision : 1.0
// ============================================================================
package mips_pkg;

  // Writes to this address go to the output port, not to the byte array.
  localparam logic [7:0] IOADDR_DEFAULT = 8'hFF;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } mem_state_e;

  // CPU opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

endpackage
`default_nettype wire

// File: rtl/mips_ram.sv
`default_nettype none
// ============================================================================
// mips_ram : single-port byte array, synchronous write, combinational read
// Revision : 1.0
// ============================================================================
module mips_ram
  import mips_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [2**WIDTH];

  // No reset: contents survive a reset so a partial reload keeps old bytes.
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end

  assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/mips_mem.sv
`default_nettype none
// ============================================================================
// mips_mem : program loader + CPU data memory with memory-mapped output port
// Revision : 1.0
// ============================================================================
module mips_mem
  import mips_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] IOADDR = WIDTH'(IOADDR_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic             cpu_hold,
  output logic [WIDTH-1:0] out_port,
  output logic             out_valid
);

  localparam logic [WIDTH-1:0] C_LAST_LOAD = IOADDR - WIDTH'(1);

  mem_state_e       r_state, w_state_next;
  logic [WIDTH-1:0] r_ptr;
  logic [WIDTH-1:0] w_ram_addr, w_ram_wdata, w_ram_rdata;
  logic             w_ram_we, w_load_accept, w_run_wr, w_run_rd, w_io_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_LOAD;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    load_ready    = 1'b0;
    cpu_hold      = 1'b0;
    w_load_accept = 1'b0;
    w_run_wr      = 1'b0;
    w_run_rd      = 1'b0;
    case (r_state)
      ST_LOAD: begin
        load_ready    = 1'b1;
        cpu_hold      = 1'b1;
        w_load_accept = load_valid;
        // Stop one short of IOADDR so loading never spills into the port.
        if (load_valid && (load_last || (r_ptr == C_LAST_LOAD)))
          w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_run_wr = memwrite;
        w_run_rd = memread & ~memwrite;
      end
      default: w_state_next = ST_LOAD;
    endcase
  end

  assign w_io_hit    = (adr == IOADDR);
  assign w_ram_we    = w_load_accept | (w_run_wr & ~w_io_hit);
  assign w_ram_addr  = (r_state == ST_LOAD) ? r_ptr : adr;
  assign w_ram_wdata = (r_state == ST_LOAD) ? load_data : writedata;

  mips_ram #(.WIDTH(WIDTH)) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (w_ram_wdata),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr     <= '0;
      memdata   <= '0;
      out_port  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (w_load_accept) r_ptr <= r_ptr + WIDTH'(1);
      if (w_run_rd) memdata <= w_io_hit ? out_port : w_ram_rdata;
      out_valid <= w_run_wr & w_io_hit;
      if (w_run_wr && w_io_hit) out_port <= writedata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_mem.sv
`default_nettype none
// ============================================================================
// tb_mips_mem : table-driven bench for mips_mem with a read-data scoreboard
// Revision : 1.0
// ============================================================================
module tb_mips_mem;

  typedef struct {
    logic       rd;
    logic       wr;
    logic       lv;
    logic [7:0] adr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    logic [7:0] exp_op;
    logic       exp_ov;
  } vec_t;

  logic       clk = 1'b0, rst = 1'b0;
  logic       memread = 1'b0, memwrite = 1'b0;
  logic       load_valid = 1'b0, load_last = 1'b0;
  logic [7:0] adr = '0, writedata = '0, load_data = '0;
  logic [7:0] memdata, out_port;
  logic       load_ready, cpu_hold, out_valid;

  int         n_cmp = 0, n_bad = 0;
  logic [7:0] sb[$];
  logic [7:0] last_md = '0;
  vec_t       tbl_a[$], tbl_b[$], tbl_c[$];

  always #5 clk = ~clk;

  mips_mem #(.WIDTH(8), .IOADDR(8'hFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .memread    (memread),
    .memwrite   (memwrite),
    .adr        (adr),
    .writedata  (writedata),
    .memdata    (memdata),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .cpu_hold   (cpu_hold),
    .out_port   (out_port),
    .out_valid  (out_valid)
  );

  function automatic vec_t mk(input logic rd, input logic wr, input logic lv,
                              input logic [7:0] a, input logic [7:0] wd,
                              input logic [7:0] er, input logic [7:0] eo,
                              input logic ev);
    vec_t v;
    v.rd = rd; v.wr = wr; v.lv = lv; v.adr = a; v.wd = wd;
    v.exp_rd = er; v.exp_op = eo; v.exp_ov = ev;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] e;
    memread    = v.rd;
    memwrite   = v.wr;
    load_valid = v.lv;
    load_data  = 8'h99;
    adr        = v.adr;
    writedata  = v.wd;
    if (v.rd && !v.wr) sb.push_back(v.exp_rd);
    step();
    memread = 1'b0; memwrite = 1'b0; load_valid = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " memdata"}, memdata, e);
      last_md = e;
    end else begin
      check({tag, " memdata hold"}, memdata, last_md);
    end
    check({tag, " out_port"}, out_port, v.exp_op);
    check({tag, " out_valid"}, out_valid, v.exp_ov);
    check({tag, " load_ready"}, load_ready, 1'b0);
  endtask

  initial begin
    // rd wr lv adr wd exp_rd exp_op exp_ov
    tbl_a.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h20, 8'h00, 0));
    tbl_a.push_back(mk(1, 0, 0, 8'h01, 8'h00, 8'h01, 8'h00, 0));
    tbl_a.push_back(mk(1, 0, 0, 8'h02, 8'h00, 8'h00, 8'h00, 0));
    tbl_a.push_back(mk(1, 0, 0, 8'h03, 8'h00, 8'h05, 8'h00, 0));
    tbl_a.push_back(mk(0, 1, 0, 8'h40, 8'hA5, 8'h00, 8'h00, 0));
    tbl_a.push_back(mk(1, 0, 0, 8'h40, 8'h00, 8'hA5, 8'h00, 0));
    tbl_a.push_back(mk(0, 1, 0, 8'hFF, 8'h3C, 8'h00, 8'h3C, 1));
    tbl_a.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h3C, 0));
    tbl_a.push_back(mk(1, 0, 0, 8'hFF, 8'h00, 8'h3C, 8'h3C, 0));
    tbl_a.push_back(mk(1, 1, 0, 8'h10, 8'h77, 8'h00, 8'h3C, 0));
    tbl_a.push_back(mk(1, 0, 0, 8'h10, 8'h00, 8'h77, 8'h3C, 0));
    tbl_a.push_back(mk(0, 1, 0, 8'hFF, 8'h11, 8'h00, 8'h11, 1));
    tbl_a.push_back(mk(0, 1, 0, 8'hFF, 8'h22, 8'h00, 8'h22, 1));
    tbl_a.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h22, 0));
    tbl_a.push_back(mk(0, 1, 0, 8'h04, 8'h5A, 8'h00, 8'h22, 0));
    tbl_a.push_back(mk(0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h22, 0));
    tbl_a.push_back(mk(1, 0, 0, 8'h04, 8'h00, 8'h5A, 8'h22, 0));
    tbl_a.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h20, 8'h22, 0));

    tbl_b.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'hCC, 8'h00, 0));
    tbl_b.push_back(mk(1, 0, 0, 8'h01, 8'h00, 8'hBB, 8'h00, 0));

    tbl_c.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h5A, 8'h00, 0));
    tbl_c.push_back(mk(1, 0, 0, 8'h80, 8'h00, 8'hDA, 8'h00, 0));
    tbl_c.push_back(mk(1, 0, 1, 8'hFE, 8'h00, 8'hA4, 8'h00, 0));
    tbl_c.push_back(mk(1, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 0));

    // Reset state
    step(); step();
    check("rst memdata", memdata, 8'h00);
    check("rst out_port", out_port, 8'h00);
    check("rst out_valid", out_valid, 1'b0);
    check("rst load_ready", load_ready, 1'b1);
    check("rst cpu_hold", cpu_hold, 1'b1);
    rst = 1'b1;
    step();

    // Four-byte program, load_last on the final byte
    load_byte(8'h20, 1'b0);
    check("load1 ready", load_ready, 1'b1);
    load_byte(8'h01, 1'b0);
    load_byte(8'h00, 1'b0);
    check("load3 hold", cpu_hold, 1'b1);
    load_byte(8'h05, 1'b1);
    check("load4 ready", load_ready, 1'b0);
    check("load4 hold", cpu_hold, 1'b0);
    last_md = 8'h00;
    foreach (tbl_a[i]) run_vec(tbl_a[i], $sformatf("A%0d", i));

    // Reset mid-RUN with a port write in flight
    memwrite = 1'b1; adr = 8'hFF; writedata = 8'hEE;
    rst = 1'b0;
    #2;
    check("midrun memdata", memdata, 8'h00);
    check("midrun out_port", out_port, 8'h00);
    check("midrun load_ready", load_ready, 1'b1);
    check("midrun cpu_hold", cpu_hold, 1'b1);
    step();
    check("midrun edge out_valid", out_valid, 1'b0);
    check("midrun edge out_port", out_port, 8'h00);
    memwrite = 1'b0;
    rst = 1'b1;

    // Reset after two loaded bytes restarts at address 0
    load_byte(8'hAA, 1'b0);
    load_byte(8'hBB, 1'b0);
    rst = 1'b0;
    #2;
    check("midload load_ready", load_ready, 1'b1);
    check("midload memdata", memdata, 8'h00);
    rst = 1'b1;
    load_byte(8'hCC, 1'b1);
    check("reload ready", load_ready, 1'b0);
    last_md = 8'h00;
    foreach (tbl_b[i]) run_vec(tbl_b[i], $sformatf("B%0d", i));

    // 255 bytes without load_last terminates automatically
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 255; i++) begin
      load_byte(8'(i) ^ 8'h5A, 1'b0);
      if (i == 253) check("auto pre ready", load_ready, 1'b1);
    end
    check("auto ready", load_ready, 1'b0);
    check("auto hold", cpu_hold, 1'b0);
    check("auto out_port", out_port, 8'h00);
    last_md = 8'h00;
    foreach (tbl_c[i]) run_vec(tbl_c[i], $sformatf("C%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_mem.md
MIPS_MEM -- requirements
Module: mips_mem

Interface
REQ-001 Parameter WIDTH, default 8, data and address width in bits.
REQ-002 Parameter IOADDR, default 8'hFF, address of the memory-mapped output port.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 memread  input  1  CPU read request.
REQ-006 memwrite  input  1  CPU write request.
REQ-007 adr  input  WIDTH  CPU byte address.
REQ-008 writedata  input  WIDTH  CPU write data.
REQ-009 memdata  output  WIDTH  registered read data returned to the CPU.
REQ-010 load_valid  input  1  loader byte valid.
REQ-011 load_data  input  WIDTH  loader byte.
REQ-012 load_last  input  1  qualifies the final loader byte; sampled with load_valid.
REQ-013 load_ready  output  1  responder accepts loader bytes.
REQ-014 cpu_hold  output  1  high keeps the CPU in reset during program load.
REQ-015 out_port  output  WIDTH  last byte written to IOADDR.
REQ-016 out_valid  output  1  one-cycle strobe on each write to IOADDR.

Function
REQ-017 Storage SHALL be 2**WIDTH bytes; location IOADDR SHALL be shadowed by out_port and never read from the array.
REQ-018 FSM SHALL have two states: LOAD and RUN.
REQ-019 In LOAD: load_ready=1, cpu_hold=1; CPU memread/memwrite are ignored; memdata holds its value.
REQ-020 In LOAD, each cycle with load_valid=1 SHALL write load_data to mem[ptr] and increment ptr (WIDTH bits).
REQ-021 LOAD->RUN on an accepted byte with load_last=1, or on an accepted byte at ptr=IOADDR-1 (auto-terminate; no wrap into IOADDR).
REQ-022 load_ready and cpu_hold SHALL drop to 0 in the cycle after the final byte is accepted; RUN is held until reset.
REQ-023 In RUN, load_valid SHALL be ignored and load_ready SHALL be 0.
REQ-024 RUN read: memread=1 at edge N -> memdata = mem[adr] (or out_port if adr=IOADDR) after edge N; latency 1 cycle.
REQ-025 memdata SHALL hold its last value whenever no read is performed.
REQ-026 RUN write: memwrite=1 at edge N -> mem[adr]=writedata after edge N; adr=IOADDR updates out_port instead and pulses out_valid for exactly the following cycle.
REQ-027 memread and memwrite both high: write is performed, memdata is not updated.
REQ-028 Read at edge N+1 of an address written at edge N SHALL return the new data.
REQ-029 Back-to-back writes to IOADDR SHALL produce one out_valid cycle per write.

Reset
REQ-030 rst=0 SHALL immediately force: state=LOAD, ptr=0, memdata=0, out_port=0, out_valid=0, load_ready=1, cpu_hold=1.
REQ-031 Array contents SHALL NOT be cleared by reset; reset mid-load restarts loading at address 0.
REQ-032 Reset mid-RUN SHALL return to LOAD, discarding any in-flight read or write in that cycle.

Structure
REQ-033 FSM state encoding and the IOADDR default SHALL live in the shared mips package alongside the CPU constants.
REQ-034 The byte array SHALL be a sub-module mips_ram (single port, synchronous write, WIDTH-parameterized); mips_mem owns the FSM, pointer, read register and I/O port.

Verification
REQ-035 Load 4 bytes 20,01,00,05 with load_last on the 4th -> mem[0..3] match, cpu_hold falls next cycle.
REQ-036 Load 255 bytes without load_last -> auto RUN after ptr=0xFE; out_port still 0.
REQ-037 RUN: memwrite adr=0x40 data=0xA5, next cycle memread adr=0x40 -> memdata=0xA5 one cycle later.
REQ-038 RUN: memwrite adr=0xFF data=0x3C -> out_port=0x3C, out_valid high exactly one cycle; read 0xFF returns 0x3C.
REQ-039 memread+memwrite same cycle adr=0x10 data=0x77 -> mem[0x10]=0x77, memdata unchanged.
REQ-040 Assert rst after 2 loaded bytes -> state LOAD, ptr=0, memdata=0; next load overwrites mem[0].
